cgra_config_loader: RTL and testbench

//  Transmit end of the PE configuration scan chain. Accepts configuration words over
//  a valid/ready stream and serialises them onto the chain's config_in pin, one bit per

---
 rtl/cgra_config_loader_if.sv | 19 +
 rtl/cgra_config_loader.sv | 210 +++++++++++++++++++++
 tb/tb_cgra_config_loader.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cgra_config_loader_if.sv
// ---------------------------------------------------------------------------
// cgra_config_loader_if
//   Configuration word stream (valid/ready) feeding the config chain loader.
//   Ports / signals:
//     word_valid  master -> slave  word_data holds a word
//     word_ready  slave  -> master loader takes the word this cycle
//     word_data   master -> slave  configuration word, bit 0 shifted first
//   Modports: master (word source), slave (loader).
// ---------------------------------------------------------------------------
interface cgra_config_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;

    modport master (output word_valid, output word_data, input word_ready);
    modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/cgra_config_loader.sv
// ---------------------------------------------------------------------------
// cgra_config_loader
//   Head of a PE configuration scan chain. Takes configuration words from a
//   valid/ready stream and serialises them onto the chain input, one bit per
//   enabled shift cycle, LSB of each word first. A CRC-16 (poly 0x1021, init
//   0xFFFF, MSB-first) is accumulated over every bit sent.
//
//   Optional feature macro: CFG_READBACK_EN
//     When defined, after loading the chain is clocked once more around its
//     full length with its tail recirculated to its head (contents are
//     preserved) and a CRC over the returned bits is compared against the
//     transmit CRC; a mismatch raises error together with done.
//     When undefined, error is tied low and cfg_return is ignored.
//
//   Ports:
//     clk, reset   clock; asynchronous active-high reset
//     start        begin a load (only honoured while idle)
//     word         word stream (slave side of cgra_config_loader_if)
//     cfg_reset    chain config_reset
//     cfg_shift    chain shift enable (gates config_clk externally)
//     cfg_data     chain config_in
//     cfg_return   chain tail config_out
//     busy         high whenever not idle
//     done         one-cycle completion pulse
//     error        readback CRC mismatch, sticky until the next start
// ---------------------------------------------------------------------------
module cgra_config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    cgra_config_loader_if.slave  word,
    output logic                 cfg_reset,
    output logic                 cfg_shift,
    output logic                 cfg_data,
    input  logic                 cfg_return,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);
    localparam int BLW = $clog2(CHAIN_LEN + 1);
    localparam int CW  = $clog2(WORD_W + 1);
    localparam logic [BLW-1:0] CHAIN_LEN_C = BLW'(CHAIN_LEN);
    localparam logic [BLW-1:0] BL_ONE      = BLW'(1);
    localparam logic [CW-1:0]  WC_ONE      = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        SHIFT,
        READBACK,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [WORD_W-1:0] sreg, sreg_d;          // bits still to send after cfg_data
    logic [BLW-1:0]    bits_left, bits_left_d;
    logic [CW-1:0]     word_cnt, word_cnt_d;  // bits of current word still to send
    logic              clr_cnt, clr_cnt_d;
    logic              data_q, data_d;
    logic [15:0]       tx_crc, tx_crc_d;

    function automatic logic [15:0] crc16_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

`ifdef CFG_READBACK_EN
    logic [15:0] rx_crc, rx_crc_d;
    logic        error_d;
    logic        rb_q;                         // chain is recirculating
`endif

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d         = state;
        sreg_d          = sreg;
        bits_left_d     = bits_left;
        word_cnt_d      = word_cnt;
        clr_cnt_d       = clr_cnt;
        data_d          = 1'b0;
        tx_crc_d        = tx_crc;
        word.word_ready = 1'b0;
`ifdef CFG_READBACK_EN
        rx_crc_d        = rx_crc;
        error_d         = error;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = 1'b0;
`ifdef CFG_READBACK_EN
                    error_d   = 1'b0;
`endif
                end
            end
            CLEAR: begin
                bits_left_d = CHAIN_LEN_C;
                tx_crc_d    = 16'hFFFF;
                clr_cnt_d   = 1'b1;
                if (clr_cnt) state_d = FETCH;
            end
            FETCH: begin
                word.word_ready = 1'b1;
                if (word.word_valid) begin
                    state_d = SHIFT;
                    data_d  = word.word_data[0];
                    sreg_d  = word.word_data >> 1;
                    // the final word may carry more bits than the chain has left
                    word_cnt_d = (int'(bits_left) >= WORD_W) ? CW'(WORD_W) : CW'(bits_left);
                end
            end
            SHIFT: begin
                // the bit on cfg_data is captured by the chain at this edge
                tx_crc_d    = crc16_bit(tx_crc, data_q);
                bits_left_d = (bits_left != '0) ? bits_left - BL_ONE : '0;
                word_cnt_d  = (word_cnt != '0) ? word_cnt - WC_ONE : '0;
                if (word_cnt > WC_ONE) begin
                    data_d = sreg[0];
                    sreg_d = sreg >> 1;
                end else if (bits_left > BL_ONE) begin
                    state_d = FETCH;
                end else begin
`ifdef CFG_READBACK_EN
                    state_d     = READBACK;
                    bits_left_d = CHAIN_LEN_C;
                    rx_crc_d    = 16'hFFFF;
`else
                    state_d     = DONE;
`endif
                end
            end
`ifdef CFG_READBACK_EN
            READBACK: begin
                rx_crc_d    = crc16_bit(rx_crc, cfg_return);
                bits_left_d = (bits_left != '0) ? bits_left - BL_ONE : '0;
                if (bits_left <= BL_ONE) begin
                    state_d = DONE;
                    if (crc16_bit(rx_crc, cfg_return) != tx_crc) error_d = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- state and registered outputs ----------------
    // Chain-facing outputs are flops so the config_clk gate never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            bits_left <= '0;
            word_cnt  <= '0;
            clr_cnt   <= 1'b0;
            data_q    <= 1'b0;
            tx_crc    <= '0;
            cfg_reset <= 1'b0;
            cfg_shift <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            sreg      <= sreg_d;
            bits_left <= bits_left_d;
            word_cnt  <= word_cnt_d;
            clr_cnt   <= clr_cnt_d;
            data_q    <= data_d;
            tx_crc    <= tx_crc_d;
            cfg_reset <= (state_d == CLEAR);
            cfg_shift <= (state_d == SHIFT) || (state_d == READBACK);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_crc <= '0;
            error  <= 1'b0;
            rb_q   <= 1'b0;
        end else begin
            rx_crc <= rx_crc_d;
            error  <= error_d;
            rb_q   <= (state_d == READBACK);
        end
    end

    // Tail feeds straight back to the head so one full lap restores the chain;
    // cfg_return itself only moves on config_clk edges.
    assign cfg_data = rb_q ? cfg_return : data_q;
`else
    logic unused_return;
    assign unused_return = cfg_return;
    assign error         = 1'b0;
    assign cfg_data      = data_q;
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
module tb_cgra_config_loader;
    localparam int WORD_W    = 4;
    localparam int CHAIN_LEN = 9;
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int STUCK_BIT = 4;
`ifdef CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        int                   lat;
        logic                 err;
        logic [CHAIN_LEN-1:0] chain;
        int                   shifts;
        int                   words;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cfg_reset, cfg_shift, cfg_data, cfg_return, busy, done, error;

    cgra_config_loader_if #(.WORD_W(WORD_W)) wif ();

    cgra_config_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word       (wif),
        .cfg_reset  (cfg_reset),
        .cfg_shift  (cfg_shift),
        .cfg_data   (cfg_data),
        .cfg_return (cfg_return),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Scan chain model: new bit enters at the top, tail is bit 0.
    logic [CHAIN_LEN-1:0] chain      = '0;
    logic [CHAIN_LEN-1:0] stuck_mask = '0;
    assign cfg_return = chain[0];
    always @(posedge clk) begin
        if (cfg_reset)      chain <= '0;
        else if (cfg_shift) chain <= {cfg_data, chain[CHAIN_LEN-1:1]} & ~stuck_mask;
    end

    int   n_pass = 0;
    int   n_total = 0;
    logic exp_bits[$];
    exp_t exp_done[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] crc16(input logic [CHAIN_LEN-1:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < CHAIN_LEN; k++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[k]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    int t_start = 0;
    int shift_idx = 0;
    int hs = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                shift_idx = 0;
                hs        = 0;
            end else begin
                if (start && !busy) begin
                    t_start   = cyc;
                    shift_idx = 0;
                    hs        = 0;
                end
                if (wif.word_valid && wif.word_ready) hs++;
                if (wif.word_ready) check("shift_in_fetch", cfg_shift, 0);
                if (cfg_shift) begin
                    if (shift_idx < CHAIN_LEN) begin
                        if (exp_bits.size() == 0) check("bit_queue_size", exp_bits.size(), 1);
                        else check("cfg_data_bit", cfg_data, exp_bits.pop_front());
                    end
                    shift_idx++;
                end
                if (done) begin
                    if (exp_done.size() == 0) check("done_queue_size", exp_done.size(), 1);
                    else begin
                        e = exp_done.pop_front();
                        check("latency", cyc - t_start - 1, e.lat);
                        check("error_flag", error, e.err);
                        check("chain_value", chain, e.chain);
                        check("shift_count", shift_idx, e.shifts);
                        check("words_accepted", hs, e.words);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [NW-1:0][WORD_W-1:0] w, input int gap,
                            input bit busy_start, input bit abort);
        logic [CHAIN_LEN-1:0] bits, c_load, rb_bits;
        exp_t e;
        int   waited;
        bit   stuck;
        stuck = (stuck_mask != '0);
        // Reference: chain bit k is stream bit k (words LSB first, excess dropped);
        // a stuck cell zeroes every bit that passes through it.
        for (int k = 0; k < CHAIN_LEN; k++) begin
            bits[k]   = w[k / WORD_W][k % WORD_W];
            c_load[k] = (stuck && k <= STUCK_BIT) ? 1'b0 : bits[k];
        end
        for (int j = 0; j < CHAIN_LEN; j++)
            rb_bits[j] = (stuck && j >= STUCK_BIT) ? 1'b0 : c_load[j];
        e.lat    = 2 + NW + CHAIN_LEN + gap * (NW - 1) + (RB ? CHAIN_LEN : 0);
        e.err    = RB && (crc16(bits) != crc16(rb_bits));
        e.chain  = (RB && stuck) ? '0 : c_load;
        e.shifts = RB ? 2 * CHAIN_LEN : CHAIN_LEN;
        e.words  = NW;
        for (int k = 0; k < CHAIN_LEN; k++) exp_bits.push_back(bits[k]);
        if (!abort) exp_done.push_back(e);

        start = 1'b1;
        step();
        start = 1'b0;
        check("error_cleared_on_start", error, 0);
        for (int i = 0; i < NW; i++) begin
            waited = 0;
            while (!wif.word_ready && waited < 100) begin step(); waited++; end
            check("word_ready_wait", wif.word_ready, 1);
            repeat ((i == 0) ? 0 : gap) step();
            wif.word_valid = 1'b1;
            wif.word_data  = w[i];
            step();
            wif.word_valid = 1'b0;
            if (i == 0 && busy_start) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            if (abort) begin
                step();
                step();
                #2 reset = 1'b1;
                #1 check("reset_mid_shift_outputs",
                         {wif.word_ready, cfg_reset, cfg_shift, cfg_data, busy, done, error}, 0);
                exp_bits.delete();
                step();
                reset = 1'b0;
                step();
                return;
            end
        end
        waited = 0;
        while (!done && waited < 200) begin step(); waited++; end
        check("done_seen", done, 1);
        step();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        step();
    endtask

    initial begin
        logic [NW-1:0][WORD_W-1:0] pat;
        logic [NW-1:0][WORD_W-1:0] rw;
        pat = {4'h1, 4'h5, 4'hA};
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {wif.word_ready, cfg_reset, cfg_shift, cfg_data, busy, done, error}, 0);
        reset = 1'b0;
        step();

        run_load(pat, 0, 1'b0, 1'b1);   // abort by reset mid-shift
        run_load(pat, 0, 1'b0, 1'b0);   // clean reload, back-to-back words
        run_load(pat, 5, 1'b0, 1'b0);   // stalled stream between words
        run_load(pat, 0, 1'b1, 1'b0);   // start while busy is ignored
`ifdef CFG_READBACK_EN
        stuck_mask = '0;
        stuck_mask[STUCK_BIT] = 1'b1;
        run_load(pat, 0, 1'b0, 1'b0);   // faulty chain -> error with done
        stuck_mask = '0;
        run_load(pat, 0, 1'b0, 1'b0);   // error cleared by the next start
`endif
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NW; i++) rw[i] = WORD_W'($urandom_range(0, (1 << WORD_W) - 1));
            run_load(rw, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) step();
        check("done_queue_drained", exp_done.size(), 0);
        check("bit_queue_drained", exp_bits.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
